mc_datapath: RTL and testbench
==============================

MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 Parameter XLEN, default 32, data/address width; legal values are 32 and 64.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-low reset.
REQ-005 Ports ResultSrc in 2, PCSrc in 1, ALUSrc in 1, RegWrite in 1, ImmSrc in 2, ALUControl in 3, Jalr in 1, MemRead in 1, MemWrite in 1  decoded control, sampled only in EXEC/WB.
REQ-006 Port Instr  out  32  instruction register (IR) contents, feeds the external decoder.
REQ-007 Ports Zero out 1 and ALUR31 out 1  ALU result == 0 and ALU result MSB, valid in EXEC.
REQ-008 Ports mem_req out 1, mem_we out 1, mem_addr out XLEN, mem_wdata out XLEN, mem_rdata in XLEN, mem_ready in 1  single-port memory handshake.
REQ-009 Port state  out  2  current sequencer state, for debug.

Function
REQ-010 Sequencer states are FETCH=0, EXEC=1, MEM=2, WB=3.
REQ-011 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on mem_ready=1, IR<=mem_rdata[31:0] and go to EXEC; otherwise hold, with outputs unchanged.
REQ-012 EXEC: combinational ALU on SrcA=rs1 and SrcB=(ALUSrc ? ImmExt : rs2); ALUOut is registered; next state is MEM if MemRead or MemWrite, else WB.
REQ-013 MEM: mem_req=1, mem_we=MemWrite, mem_addr=ALUOut, mem_wdata=rs2; on mem_ready, MDR<=mem_rdata and go to WB; mem_req and mem_we are 0 in EXEC and WB.
REQ-014 WB: if RegWrite and rd!=0, write Result to rd; PC<=Jalr ? {ALUOut[XLEN-1:1],1'b0} : PCSrc ? PC+ImmExt : PC+4; go to FETCH.
REQ-015 Result select by ResultSrc: 00 ALUOut, 01 MDR, 10 PC+4, 11 upper-immediate (Instr[5]=1 gives LUI value, else AUIPC=PC+imm).
REQ-016 Upper immediate is sign-extended to XLEN.
REQ-017 ImmSrc: 00 I, 01 S, 10 B, 11 J; all immediates are sign-extended to XLEN.
REQ-018 ALUControl: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 111 sltu, 110 shift (funct3 001 sll; 101 srl, or sra when Instr[30]=1); shift amount is SrcB[$clog2(XLEN)-1:0].
REQ-019 Add/sub wraps modulo 2^XLEN; slt is signed, sltu is unsigned.
REQ-020 Register file: 32 x XLEN, two asynchronous reads, one synchronous write; x0 reads 0 and writes to it are discarded.
REQ-021 A write and a read of the same register in the same cycle returns the old value (no bypass; the multicycle order makes a bypass unnecessary).
REQ-022 mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.
REQ-023 mem_ready while mem_req=0 is ignored.
REQ-024 Every instruction takes 3 cycles plus FETCH wait states if it has no MEM phase, and 4 cycles plus all wait states if it has one.

Reset
REQ-025 While reset=0, state=FETCH, PC=RESET_PC, IR=32'h00000013 (NOP), ALUOut=0, MDR=0, mem_req=0.
REQ-026 The register file is not reset.
REQ-027 Reset asserted mid-transaction aborts it immediately; no register write and no PC update occur.
REQ-028 The first mem_req=1 appears in the first cycle after reset is released.

Configuration
REQ-029 Macro MC_DATAPATH_PERF_CNT_EN, when defined, adds outputs cycle_cnt (64, increments every cycle out of reset) and instret_cnt (64, increments on each WB); both wrap at 2^64 and reset to 0.
REQ-030 When MC_DATAPATH_PERF_CNT_EN is undefined, those ports and counters do not exist and all other behaviour is identical.

Structure
REQ-031 Package mc_pkg holds the state encoding enum, the ALUControl, ImmSrc and ResultSrc localparams, and the NOP constant.
REQ-032 Sub-module mc_regfile holds the register file, parameterised by XLEN; the sequencer, ALU and immediate extension stay in mc_datapath.

Verification
REQ-033 Release reset with RESET_PC=0x100 and mem_ready=1 -> mem_addr=0x100 on the first request, and state steps 0,1,3,0.
REQ-034 Run addi x1,x0,-1, then sw x1,8(x0) with mem_ready low 3 cycles in MEM -> mem_we=1, mem_addr=8, mem_wdata=all-ones held stable 4 cycles, and the instruction takes 7 cycles.
REQ-035 Run beq x0,x0,+16 at PC=0x20 -> Zero=1 in EXEC, next fetch address 0x30; with x1!=x0 (bne decoded PCSrc=0) -> 0x24.
REQ-036 Run jalr x5,x1,3 with x1=0x40 -> x5=PC+4 and next PC=0x42.
REQ-037 Run addi x0,x0,5 -> x0 still reads 0; sra with x1=0x80000000 by 4 at XLEN=32 -> 0xF8000000.
REQ-038 Assert reset mid-MEM of a load -> rd unchanged, PC=RESET_PC; with MC_DATAPATH_PERF_CNT_EN defined, instret_cnt=0 after reset and 2 after two further instructions.

Source files
------------

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multicycle datapath
package mc_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_WB    = 2'd3
  } mc_state_e;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] ALU_SHIFT = 3'b110;
  localparam logic [2:0] ALU_SLTU  = 3'b111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALU   = 2'b00;
  localparam logic [1:0] RES_MDR   = 2'b01;
  localparam logic [1:0] RES_PC4   = 2'b10;
  localparam logic [1:0] RES_UPPER = 2'b11;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/mc_datapath_if.sv
// rtl/mc_datapath_if.sv - single-port memory handshake between datapath and memory
interface mc_datapath_if #(parameter int unsigned XLEN = 32);
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ready);
  modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ready);
endinterface

// File: rtl/mc_regfile.sv
// rtl/mc_regfile.sv - 32-entry register file, two async reads, one sync write, x0 hardwired
module mc_regfile #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);
  logic [XLEN-1:0] regs [32];

  always_ff @(posedge clk) begin
    if (we && waddr != 5'd0) regs[waddr] <= wdata;
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : regs[raddr2];
endmodule

// File: rtl/mc_datapath.sv
// rtl/mc_datapath.sv - multicycle datapath: FETCH/EXEC/MEM/WB sequencer, ALU, immediates
// Define MC_DATAPATH_PERF_CNT_EN to add cycle_cnt and instret_cnt outputs.
module mc_datapath
  import mc_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    ResultSrc,
  input  logic          PCSrc,
  input  logic          ALUSrc,
  input  logic          RegWrite,
  input  logic [1:0]    ImmSrc,
  input  logic [2:0]    ALUControl,
  input  logic          Jalr,
  input  logic          MemRead,
  input  logic          MemWrite,
  output logic [31:0]   Instr,
  output logic          Zero,
  output logic          ALUR31,
  mc_datapath_if.master mem,
  output logic [1:0]    state
`ifdef MC_DATAPATH_PERF_CNT_EN
  ,
  output logic [63:0]   cycle_cnt,
  output logic [63:0]   instret_cnt
`endif
);
  localparam int SHW = $clog2(XLEN);

  mc_state_e       cur_st, nxt_st;
  logic [XLEN-1:0] pc, alu_out, mdr;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_ext, imm_upper, src_b, alu_res;
  logic [XLEN-1:0] pc_plus4, pc_next, result;

  mc_regfile #(.XLEN(XLEN)) u_regfile (
    .clk    (clk),
    .we     (cur_st == ST_WB && RegWrite),
    .waddr  (Instr[11:7]),
    .wdata  (result),
    .raddr1 (Instr[19:15]),
    .raddr2 (Instr[24:20]),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  assign state = cur_st;

  always_comb begin
    imm_ext = '0;
    case (ImmSrc)
      IMM_I: imm_ext = XLEN'($signed(Instr[31:20]));
      IMM_S: imm_ext = XLEN'($signed({Instr[31:25], Instr[11:7]}));
      IMM_B: imm_ext = XLEN'($signed({Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0}));
      IMM_J: imm_ext = XLEN'($signed({Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0}));
      default: imm_ext = '0;
    endcase
  end

  assign imm_upper = XLEN'($signed({Instr[31:12], 12'b0}));
  assign src_b     = ALUSrc ? imm_ext : rs2_val;

  always_comb begin
    alu_res = '0;
    case (ALUControl)
      ALU_ADD:  alu_res = rs1_val + src_b;
      ALU_SUB:  alu_res = rs1_val - src_b;
      ALU_AND:  alu_res = rs1_val & src_b;
      ALU_OR:   alu_res = rs1_val | src_b;
      ALU_XOR:  alu_res = rs1_val ^ src_b;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(rs1_val) < $signed(src_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, rs1_val < src_b};
      ALU_SHIFT: begin
        // funct3 picks left vs right; Instr[30] turns a right shift arithmetic
        if (Instr[14:12] == 3'b001)
          alu_res = rs1_val << src_b[SHW-1:0];
        else if (Instr[30])
          alu_res = $signed(rs1_val) >>> src_b[SHW-1:0];
        else
          alu_res = rs1_val >> src_b[SHW-1:0];
      end
      default: alu_res = '0;
    endcase
  end

  assign Zero   = (alu_res == '0);
  assign ALUR31 = alu_res[XLEN-1];

  assign pc_plus4 = pc + XLEN'(4);
  assign pc_next  = Jalr  ? {alu_out[XLEN-1:1], 1'b0} :
                    PCSrc ? pc + imm_ext : pc_plus4;

  always_comb begin
    result = alu_out;
    case (ResultSrc)
      RES_ALU:   result = alu_out;
      RES_MDR:   result = mdr;
      RES_PC4:   result = pc_plus4;
      RES_UPPER: result = Instr[5] ? imm_upper : pc + imm_upper;
      default:   result = alu_out;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur_st <= ST_FETCH;
    else        cur_st <= nxt_st;
  end

  // mem_req is gated by reset so no request is seen while held in reset
  always_comb begin
    nxt_st        = cur_st;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = pc;
    mem.mem_wdata = rs2_val;
    case (cur_st)
      ST_FETCH: begin
        mem.mem_req = reset;
        if (mem.mem_ready) nxt_st = ST_EXEC;
      end
      ST_EXEC: nxt_st = (MemRead || MemWrite) ? ST_MEM : ST_WB;
      ST_MEM: begin
        mem.mem_req  = reset;
        mem.mem_we   = reset && MemWrite;
        mem.mem_addr = alu_out;
        if (mem.mem_ready) nxt_st = ST_WB;
      end
      ST_WB:   nxt_st = ST_FETCH;
      default: nxt_st = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      Instr   <= NOP;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      case (cur_st)
        ST_FETCH: if (mem.mem_ready) Instr <= mem.mem_rdata[31:0];
        ST_EXEC:  alu_out <= alu_res;
        ST_MEM:   if (mem.mem_ready) mdr <= mem.mem_rdata;
        ST_WB:    pc <= pc_next;
        default:  ;
      endcase
    end
  end

`ifdef MC_DATAPATH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      if (cur_st == ST_WB) instret_cnt <= instret_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_datapath.sv
// tb/tb_mc_datapath.sv - scoreboard bench: memory requests checked against a queue of expected transactions
module tb_mc_datapath;

  typedef struct packed {
    logic [1:0] res;
    logic       pcsrc;
    logic       alusrc;
    logic       regw;
    logic [1:0] imm;
    logic [2:0] alu;
    logic       jalr;
    logic       mrd;
    logic       mwr;
  } ctrl_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  localparam ctrl_t C_ADDI  = '{res:2'b00, pcsrc:1'b0, alusrc:1'b1, regw:1'b1, imm:2'b00, alu:3'b000, jalr:1'b0, mrd:1'b0, mwr:1'b0};
  localparam ctrl_t C_SW    = '{res:2'b00, pcsrc:1'b0, alusrc:1'b1, regw:1'b0, imm:2'b01, alu:3'b000, jalr:1'b0, mrd:1'b0, mwr:1'b1};
  localparam ctrl_t C_LW    = '{res:2'b01, pcsrc:1'b0, alusrc:1'b1, regw:1'b1, imm:2'b00, alu:3'b000, jalr:1'b0, mrd:1'b1, mwr:1'b0};
  localparam ctrl_t C_LUI   = '{res:2'b11, pcsrc:1'b0, alusrc:1'b0, regw:1'b1, imm:2'b00, alu:3'b000, jalr:1'b0, mrd:1'b0, mwr:1'b0};
  localparam ctrl_t C_SRAI  = '{res:2'b00, pcsrc:1'b0, alusrc:1'b1, regw:1'b1, imm:2'b00, alu:3'b110, jalr:1'b0, mrd:1'b0, mwr:1'b0};
  localparam ctrl_t C_JALR  = '{res:2'b10, pcsrc:1'b0, alusrc:1'b1, regw:1'b1, imm:2'b00, alu:3'b000, jalr:1'b1, mrd:1'b0, mwr:1'b0};
  localparam ctrl_t C_JR0   = '{res:2'b10, pcsrc:1'b0, alusrc:1'b1, regw:1'b0, imm:2'b00, alu:3'b000, jalr:1'b1, mrd:1'b0, mwr:1'b0};
  localparam ctrl_t C_BEQ_T = '{res:2'b00, pcsrc:1'b1, alusrc:1'b0, regw:1'b0, imm:2'b10, alu:3'b001, jalr:1'b0, mrd:1'b0, mwr:1'b0};
  localparam ctrl_t C_BEQ_N = '{res:2'b00, pcsrc:1'b0, alusrc:1'b0, regw:1'b0, imm:2'b10, alu:3'b001, jalr:1'b0, mrd:1'b0, mwr:1'b0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  ResultSrc, ImmSrc;
  logic [2:0]  ALUControl;
  logic        PCSrc, ALUSrc, RegWrite, Jalr, MemRead, MemWrite;
  logic [31:0] Instr;
  logic        Zero, ALUR31;
  logic [1:0]  state;
  logic [31:0] mem_rdata;
  logic        mem_ready;
`ifdef MC_DATAPATH_PERF_CNT_EN
  logic [63:0] cycle_cnt, instret_cnt;
`endif

  mc_datapath_if #(.XLEN(32)) mif ();
  assign mif.mem_rdata = mem_rdata;
  assign mif.mem_ready = mem_ready;

  mc_datapath #(.XLEN(32), .RESET_PC(32'h100)) dut (
    .clk        (clk),
    .reset      (reset),
    .ResultSrc  (ResultSrc),
    .PCSrc      (PCSrc),
    .ALUSrc     (ALUSrc),
    .RegWrite   (RegWrite),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl),
    .Jalr       (Jalr),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .Instr      (Instr),
    .Zero       (Zero),
    .ALUR31     (ALUR31),
    .mem        (mif),
    .state      (state)
`ifdef MC_DATAPATH_PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass = 0;
  req_t sb[$];
  logic [5:0] last_trace;
  logic       last_zero, last_r31;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Monitor: every cycle a request is presented it must match the queue head; pop on handshake
  initial begin
    req_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset && mif.mem_req) begin
        if (sb.size() == 0) begin
          if (mem_ready) begin
            n_checks++;
            $display("FAIL unexpected request: addr %h we %b, expected none", mif.mem_addr, mif.mem_we);
          end
        end else begin
          e = sb[0];
          chk("req we", {63'd0, mif.mem_we}, {63'd0, e.we});
          chk("req addr", {32'd0, mif.mem_addr}, {32'd0, e.addr});
          if (e.we) chk("req wdata", {32'd0, mif.mem_wdata}, {32'd0, e.wdata});
          if (mem_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic run(input string nm, input logic [31:0] pc, input logic [31:0] ins, input ctrl_t c,
                     input int fwait, input int mwait, input logic [31:0] ldata,
                     input logic has_mem, input logic [31:0] maddr, input logic [31:0] mwdata,
                     input int exp_cyc, input int abort_at);
    int cyc, w;
    logic [1:0] st, prev;
    logic done;
    sb.push_back('{we:1'b0, addr:pc, wdata:32'h0});
    if (has_mem) sb.push_back('{we:c.mwr, addr:maddr, wdata:mwdata});
    {ResultSrc, PCSrc, ALUSrc, RegWrite, ImmSrc, ALUControl, Jalr, MemRead, MemWrite} = c;
    cyc = 0; w = 0; prev = 2'd0; done = 1'b0; last_trace = '0;
    while (!done) begin
      st = state;
      if (st != prev) w = 0;
      prev = st;
      last_trace = {last_trace[3:0], st};
      if (st == 2'd1) begin
        last_zero = Zero;
        last_r31  = ALUR31;
      end
      if (abort_at >= 0 && st == 2'd2 && w == abort_at) begin
        reset = 1'b0;
        mem_ready = 1'b0;
        return;
      end
      case (st)
        2'd0:    begin mem_rdata = ins;   mem_ready = (w >= fwait); end
        2'd2:    begin mem_rdata = ldata; mem_ready = (w >= mwait); end
        default: begin mem_rdata = 32'hA5A5_A5A5; mem_ready = 1'b1; end
      endcase
      @(posedge clk);
      @(negedge clk);
      cyc++;
      w++;
      if (st == 2'd3) done = 1'b1;
      else if (cyc > 40) begin
        n_checks++;
        $display("FAIL %s timeout: %0d cycles without WB, expected %0d", nm, cyc, exp_cyc);
        done = 1'b1;
      end
    end
    mem_ready = 1'b0;
    chk({nm, " cycles"}, 64'(cyc), 64'(exp_cyc));
    chk({nm, " back to FETCH"}, {62'd0, state}, 64'd0);
  endtask

  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    {ResultSrc, PCSrc, ALUSrc, RegWrite, ImmSrc, ALUControl, Jalr, MemRead, MemWrite} = C_ADDI;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset state", {62'd0, state}, 64'd0);
    chk("reset mem_req", {63'd0, mif.mem_req}, 64'd0);
    chk("reset Instr", {32'd0, Instr}, 64'h13);
    chk("reset pc", {32'd0, mif.mem_addr}, 64'h100);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("first mem_req", {63'd0, mif.mem_req}, 64'd1);
`ifdef MC_DATAPATH_PERF_CNT_EN
    chk("instret after reset", instret_cnt, 64'd0);
`endif

    run("nop", 32'h100, 32'h0000_0013, C_ADDI, 0, 0, 0, 1'b0, 0, 0, 3, -1);
    chk("nop state trace", {58'd0, last_trace}, 64'b00_01_11);
`ifdef MC_DATAPATH_PERF_CNT_EN
    chk("cycle_cnt after nop", cycle_cnt, 64'd3);
`endif
    run("addi x1,-1", 32'h104, 32'hFFF0_0093, C_ADDI, 2, 0, 0, 1'b0, 0, 0, 5, -1);
`ifdef MC_DATAPATH_PERF_CNT_EN
    chk("instret after two", instret_cnt, 64'd2);
`endif
    run("sw x1", 32'h108, 32'h0010_2423, C_SW, 0, 3, 0, 1'b1, 32'h8, 32'hFFFF_FFFF, 7, -1);
    run("lw x2", 32'h10C, 32'h0080_2103, C_LW, 0, 1, 32'h1234_5678, 1'b1, 32'h8, 0, 5, -1);
    run("sw x2", 32'h110, 32'h0020_2623, C_SW, 0, 0, 0, 1'b1, 32'hC, 32'h1234_5678, 4, -1);
    run("addi x0,5", 32'h114, 32'h0050_0013, C_ADDI, 0, 0, 0, 1'b0, 0, 0, 3, -1);
    run("sw x0", 32'h118, 32'h0000_2823, C_SW, 0, 0, 0, 1'b1, 32'h10, 32'h0, 4, -1);
    run("lui x1", 32'h11C, 32'h8000_00B7, C_LUI, 0, 0, 0, 1'b0, 0, 0, 3, -1);
    run("srai x4", 32'h120, 32'h4040_D213, C_SRAI, 0, 0, 0, 1'b0, 0, 0, 3, -1);
    chk("srai ALUR31", {63'd0, last_r31}, 64'd1);
    run("sw x4", 32'h124, 32'h0040_2A23, C_SW, 0, 0, 0, 1'b1, 32'h14, 32'hF800_0000, 4, -1);
    run("addi x1,0x40", 32'h128, 32'h0400_0093, C_ADDI, 0, 0, 0, 1'b0, 0, 0, 3, -1);
    run("jalr x5", 32'h12C, 32'h0030_82E7, C_JALR, 0, 0, 0, 1'b0, 0, 0, 3, -1);
    run("sw x5", 32'h42, 32'h0050_2C23, C_SW, 0, 0, 0, 1'b1, 32'h18, 32'h130, 4, -1);
    run("jalr x0,0x20", 32'h46, 32'h0200_0067, C_JR0, 0, 0, 0, 1'b0, 0, 0, 3, -1);
    run("beq taken", 32'h20, 32'h0000_0863, C_BEQ_T, 0, 0, 0, 1'b0, 0, 0, 3, -1);
    chk("beq taken Zero", {63'd0, last_zero}, 64'd1);
    run("beq not taken", 32'h30, 32'h0000_8863, C_BEQ_N, 0, 0, 0, 1'b0, 0, 0, 3, -1);
    chk("beq not taken Zero", {63'd0, last_zero}, 64'd0);

    run("lw abort", 32'h34, 32'h0080_2103, C_LW, 0, 10, 32'hDEAD_BEEF, 1'b1, 32'h8, 0, 0, 2);
    #1;
    chk("abort leftover", 64'(sb.size()), 64'd1);
    if (sb.size() > 0) void'(sb.pop_front());
    chk("abort state", {62'd0, state}, 64'd0);
    chk("abort mem_req", {63'd0, mif.mem_req}, 64'd0);
    chk("abort Instr", {32'd0, Instr}, 64'h13);
    chk("abort pc", {32'd0, mif.mem_addr}, 64'h100);
`ifdef MC_DATAPATH_PERF_CNT_EN
    chk("instret after abort", instret_cnt, 64'd0);
`endif
    @(negedge clk);
    reset = 1'b1;
    run("sw x2 after reset", 32'h100, 32'h0020_2623, C_SW, 0, 0, 0, 1'b1, 32'hC, 32'h1234_5678, 4, -1);
    run("nop after reset", 32'h104, 32'h0000_0013, C_ADDI, 0, 0, 0, 1'b0, 0, 0, 3, -1);
`ifdef MC_DATAPATH_PERF_CNT_EN
    chk("instret two after abort", instret_cnt, 64'd2);
`endif
    chk("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
